ram_1rw_arb: RTL and testbench

Multi-channel front end for a single-port, byte-maskable SRAM, with an internal memory array that has 1RW macro semantics. Up to `Channels` requesters share one port through valid/ready handshakes under round-robin or fixed-priority arbitration. Each granted access produces a registered response that flags out-of-range addresses. The block sits between BIO/CPU-side masters and local scratch RAM, replacing ad-hoc muxing in front of bare RAM models.

---
 rtl/ram_arb_pkg.sv | 20 ++
 rtl/ram_1rw_arb_rr_arbiter.sv | 62 ++++++
 rtl/ram_1rw_arb.sv | 137 +++++++++++++
 tb/tb_ram_1rw_arb.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ram_arb_pkg                                            |
// | Description : Shared constants and helpers for the multi-channel     |
// |               single-port RAM front end.                             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package ram_arb_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Width of an index into n items; never narrower than one bit so that
    // single-item configurations still get a legal vector.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_1rw_arb_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rr_arbiter                                             |
// | Description : Combinational one-hot grant with round-robin or fixed  |
// |               priority; the round-robin pointer moves on grants only.|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int Mode = ARB_RR
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int c_IDX_W = idx_width(N);

    logic [c_IDX_W-1:0] r_rr_ptr;
    logic [c_IDX_W-1:0] w_gnt_idx;
    logic [c_IDX_W-1:0] w_ptr_next;
    logic               w_found;
    int                 w_cand;

    // Search from the pointer (or from channel 0 in fixed mode) for the first
    // requester; nothing is granted while reset is held.
    always_comb begin
        gnt       = '0;
        w_gnt_idx = '0;
        w_found   = 1'b0;
        w_cand    = 0;
        for (int off = 0; off < N; off++) begin
            w_cand = (Mode == ARB_FIXED) ? off : ((int'(r_rr_ptr) + off) % N);
            for (int j = 0; j < N; j++) begin
                if (!w_found && req[j] && (j == w_cand)) begin
                    w_found   = 1'b1;
                    gnt[j]    = 1'b1;
                    w_gnt_idx = c_IDX_W'(j);
                end
            end
        end
        if (reset) begin
            gnt = '0;
        end
        w_ptr_next = ((int'(w_gnt_idx) + 1) >= N) ? '0 : (w_gnt_idx + 1'b1);
    end

    // Pointer holds the channel after the last one granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (advance && (Mode == ARB_RR)) begin
            r_rr_ptr <= w_ptr_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_1rw_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ram_1rw_arb                                            |
// | Description : Arbitrated multi-channel front end for a byte-maskable |
// |               1RW memory array with registered, range-checked        |
// |               responses.                                             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ram_1rw_arb
    import ram_arb_pkg::*;
#(
    parameter int Channels     = 4,
    parameter int AddressWidth = 9,
    parameter int wordCount    = 512,
    parameter int DataWidth    = 32,
    parameter int wrMaskWidth  = 4,
    parameter int ArbMode      = ARB_RR
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [Channels-1:0]              req_valid,
    output logic [Channels-1:0]              req_ready,
    input  logic [Channels-1:0]              req_write,
    input  logic [Channels*AddressWidth-1:0] req_addr,
    input  logic [Channels*DataWidth-1:0]    req_wdata,
    input  logic [Channels*wrMaskWidth-1:0]  req_mask,
    output logic [Channels-1:0]              rsp_valid,
    output logic [DataWidth-1:0]             rsp_rdata,
    output logic                             rsp_err
);

    localparam int c_IDX_W  = idx_width(Channels);
    localparam int c_LANE_W = DataWidth / wrMaskWidth;
    localparam int c_MEM_AW = idx_width(wordCount);
    // One extra bit so a word count of exactly 2**AddressWidth still compares.
    localparam logic [AddressWidth:0] c_WORDS = (AddressWidth + 1)'(wordCount);

    logic [Channels-1:0]     w_gnt;
    logic                    w_any;
    logic [c_IDX_W-1:0]      w_sel;
    logic                    w_write;
    logic [AddressWidth-1:0] w_addr;
    logic [DataWidth-1:0]    w_wdata;
    logic [wrMaskWidth-1:0]  w_mask;
    logic                    w_in_range;
    logic [c_MEM_AW-1:0]     w_mem_idx;
    logic                    w_do_write;

    logic [DataWidth-1:0]    r_mem [wordCount];
    logic                    r_rsp_fire;
    logic [c_IDX_W-1:0]      r_rsp_ch;
    logic [DataWidth-1:0]    r_rsp_rdata;
    logic                    r_rsp_err;

    rr_arbiter #(
        .N    (Channels),
        .Mode (ArbMode)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (w_any),
        .gnt     (w_gnt)
    );

    assign req_ready = w_gnt;
    assign w_any     = |w_gnt;

    // Steer the granted channel's request onto the single memory port.
    always_comb begin
        w_sel   = '0;
        w_write = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        w_mask  = '0;
        for (int i = 0; i < Channels; i++) begin
            if (w_gnt[i]) begin
                w_sel   = c_IDX_W'(i);
                w_write = req_write[i];
                w_addr  = req_addr[i*AddressWidth +: AddressWidth];
                w_wdata = req_wdata[i*DataWidth +: DataWidth];
                w_mask  = req_mask[i*wrMaskWidth +: wrMaskWidth];
            end
        end
    end

    assign w_in_range = ({1'b0, w_addr} < c_WORDS);
    assign w_mem_idx  = w_addr[c_MEM_AW-1:0];
    // An all-zero mask degenerates to a read; out-of-range writes are dropped.
    assign w_do_write = w_any && w_write && w_in_range && (|w_mask);

    // Lane-masked write into the array; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int l = 0; l < wrMaskWidth; l++) begin
                if (w_mask[l]) begin
                    r_mem[w_mem_idx][l*c_LANE_W +: c_LANE_W] <= w_wdata[l*c_LANE_W +: c_LANE_W];
                end
            end
        end
    end

    // Capture the pre-write word and the granted channel for the next cycle;
    // data and error hold between responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_fire  <= 1'b0;
            r_rsp_ch    <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_fire <= w_any;
            if (w_any) begin
                r_rsp_ch    <= w_sel;
                r_rsp_rdata <= w_in_range ? r_mem[w_mem_idx] : '0;
                r_rsp_err   <= !w_in_range;
            end
        end
    end

    // Decode the response strobe; a response landing in a reset cycle is dropped.
    always_comb begin
        rsp_valid = '0;
        if (r_rsp_fire && !reset) begin
            for (int i = 0; i < Channels; i++) begin
                if (r_rsp_ch == c_IDX_W'(i)) begin
                    rsp_valid[i] = 1'b1;
                end
            end
        end
    end

    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_ram_1rw_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_ram_1rw_arb                                         |
// | Description : Directed self-checking bench; instance a is round-robin|
// |               with 512 words, instance b is fixed priority, 500 words|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_ram_1rw_arb;

    localparam int N  = 4;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int MW = 4;

    logic clk;
    logic reset;

    logic [N-1:0]    a_valid, a_ready, a_write, a_rsp_valid;
    logic [N*AW-1:0] a_addr;
    logic [N*DW-1:0] a_wdata;
    logic [N*MW-1:0] a_mask;
    logic [DW-1:0]   a_rdata;
    logic            a_err;

    logic [N-1:0]    b_valid, b_ready, b_write, b_rsp_valid;
    logic [N*AW-1:0] b_addr;
    logic [N*DW-1:0] b_wdata;
    logic [N*MW-1:0] b_mask;
    logic [DW-1:0]   b_rdata;
    logic            b_err;

    int total = 0;
    int bad   = 0;

    ram_1rw_arb #(
        .Channels(N), .AddressWidth(AW), .wordCount(512),
        .DataWidth(DW), .wrMaskWidth(MW), .ArbMode(0)
    ) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
        .req_addr(a_addr), .req_wdata(a_wdata), .req_mask(a_mask),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .rsp_err(a_err)
    );

    ram_1rw_arb #(
        .Channels(N), .AddressWidth(AW), .wordCount(500),
        .DataWidth(DW), .wrMaskWidth(MW), .ArbMode(1)
    ) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
        .req_addr(b_addr), .req_wdata(b_wdata), .req_mask(b_mask),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .rsp_err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a single request on instance a, set up on the falling edge.
    task automatic drive_a(input int ch, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [MW-1:0] mask);
        @(negedge clk);
        a_valid = '0;
        a_write = '0;
        a_valid[ch] = 1'b1;
        a_write[ch] = wr;
        a_addr[ch*AW +: AW]  = addr;
        a_wdata[ch*DW +: DW] = data;
        a_mask[ch*MW +: MW]  = mask;
        #1;
    endtask

    task automatic drive_b(input int ch, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [MW-1:0] mask);
        @(negedge clk);
        b_valid = '0;
        b_write = '0;
        b_valid[ch] = 1'b1;
        b_write[ch] = wr;
        b_addr[ch*AW +: AW]  = addr;
        b_wdata[ch*DW +: DW] = data;
        b_mask[ch*MW +: MW]  = mask;
        #1;
    endtask

    // Let the pending request be accepted, then drop all requests.
    task automatic step();
        @(posedge clk);
        #1;
        a_valid = '0;
        b_valid = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a_valid = '1;
        b_valid = '1;
        #1;
        total++; if (a_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready_a: got %b want 0000", a_ready); end
        total++; if (b_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready_b: got %b want 0000", b_ready); end
        total++; if (a_rsp_valid !== 4'b0000) begin bad++; $display("FAIL rst_rspv_a: got %b want 0000", a_rsp_valid); end
        @(negedge clk);
        reset   = 1'b0;
        a_valid = '0;
        b_valid = '0;
        #1;
        total++; if (a_rsp_valid !== 4'b0000) begin bad++; $display("FAIL rst_rspv_after: got %b want 0000", a_rsp_valid); end
        total++; if (a_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata_a: got %h want 0", a_rdata); end
        total++; if (a_err !== 1'b0) begin bad++; $display("FAIL rst_err_a: got %b want 0", a_err); end
        total++; if (b_rdata !== 32'h0 || b_err !== 1'b0) begin bad++; $display("FAIL rst_b_regs: got %h/%b want 0/0", b_rdata, b_err); end
    endtask

    task automatic test_write_read();
        drive_a(0, 1'b1, 9'd5, 32'h12345678, 4'hF);
        total++; if (a_ready !== 4'b0001) begin bad++; $display("FAIL wr0_ready: got %b want 0001", a_ready); end
        step();
        total++; if (a_rsp_valid !== 4'b0001 || a_err !== 1'b0) begin bad++; $display("FAIL wr0_rsp: got %b/%b want 0001/0", a_rsp_valid, a_err); end
        drive_a(1, 1'b1, 9'd5, 32'hDEADBEEF, 4'hF);
        total++; if (a_ready !== 4'b0010) begin bad++; $display("FAIL wr1_ready: got %b want 0010", a_ready); end
        step();
        total++; if (a_rsp_valid !== 4'b0010) begin bad++; $display("FAIL wr1_rspv: got %b want 0010", a_rsp_valid); end
        total++; if (a_rdata !== 32'h12345678) begin bad++; $display("FAIL wr1_oldword: got %h want 12345678", a_rdata); end
        drive_a(1, 1'b0, 9'd5, 32'h0, 4'h0);
        step();
        total++; if (a_rsp_valid !== 4'b0010 || a_err !== 1'b0) begin bad++; $display("FAIL rd_rsp: got %b/%b want 0010/0", a_rsp_valid, a_err); end
        total++; if (a_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data: got %h want deadbeef", a_rdata); end
        @(posedge clk); #1;
        total++; if (a_rsp_valid !== 4'b0000) begin bad++; $display("FAIL rsp_one_cycle: got %b want 0000", a_rsp_valid); end
        total++; if (a_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rdata_hold: got %h want deadbeef", a_rdata); end
    endtask

    task automatic test_masked();
        drive_a(2, 1'b1, 9'd7, 32'hAABBCCDD, 4'hF);
        step();
        drive_a(2, 1'b1, 9'd7, 32'h11223344, 4'b0101);
        total++; if (a_ready !== 4'b0100) begin bad++; $display("FAIL mask_ready: got %b want 0100", a_ready); end
        step();
        total++; if (a_rdata !== 32'hAABBCCDD) begin bad++; $display("FAIL mask_oldword: got %h want aabbccdd", a_rdata); end
        drive_a(3, 1'b0, 9'd7, 32'h0, 4'h0);
        step();
        total++; if (a_rsp_valid !== 4'b1000) begin bad++; $display("FAIL mask_rspv: got %b want 1000", a_rsp_valid); end
        total++; if (a_rdata !== 32'hAA22CC44) begin bad++; $display("FAIL mask_merge: got %h want aa22cc44", a_rdata); end
    endtask

    task automatic test_zero_mask();
        drive_a(0, 1'b1, 9'd7, 32'hFFFFFFFF, 4'h0);
        step();
        total++; if (a_rdata !== 32'hAA22CC44) begin bad++; $display("FAIL zmask_rsp: got %h want aa22cc44", a_rdata); end
        drive_a(3, 1'b0, 9'd7, 32'h0, 4'h0);
        step();
        total++; if (a_rdata !== 32'hAA22CC44) begin bad++; $display("FAIL zmask_unchanged: got %h want aa22cc44", a_rdata); end
    endtask

    // Pointer is 0 here: the last grant went to channel 3.
    task automatic test_rr();
        logic [N-1:0]  exp_oh;
        logic [DW-1:0] exp_d;
        @(negedge clk);
        a_valid = 4'b1111;
        a_write = 4'b0000;
        a_addr  = {9'd7, 9'd5, 9'd7, 9'd5};
        for (int k = 0; k < 8; k++) begin
            exp_oh = 4'(1 << (k % 4));
            exp_d  = (k % 2 == 0) ? 32'hDEADBEEF : 32'hAA22CC44;
            #1;
            total++; if (a_ready !== exp_oh) begin bad++; $display("FAIL rr_grant[%0d]: got %b want %b", k, a_ready, exp_oh); end
            @(posedge clk); #1;
            total++; if (a_rsp_valid !== exp_oh || a_rdata !== exp_d) begin bad++; $display("FAIL rr_rsp[%0d]: got %b/%h want %b/%h", k, a_rsp_valid, a_rdata, exp_oh, exp_d); end
            @(negedge clk);
        end
        a_valid = '0;
    endtask

    // Sparse requesters: pointer skips idle channels and wraps.
    task automatic test_rr_skip();
        logic [N-1:0] exp_seq [3];
        exp_seq[0] = 4'b0010;
        exp_seq[1] = 4'b1000;
        exp_seq[2] = 4'b0010;
        @(negedge clk);
        a_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (a_ready !== exp_seq[k]) begin bad++; $display("FAIL rrskip[%0d]: got %b want %b", k, a_ready, exp_seq[k]); end
            @(negedge clk);
        end
        a_valid = '0;
    endtask

    // Pointer is 2 here, so channel 2 wins; afterwards the pointer would be 3.
    task automatic test_mid_reset();
        @(negedge clk);
        a_valid = 4'b1100;
        #1;
        total++; if (a_ready !== 4'b0100) begin bad++; $display("FAIL mrst_pre: got %b want 0100", a_ready); end
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        total++; if (a_rsp_valid !== 4'b0000) begin bad++; $display("FAIL mrst_suppress: got %b want 0000", a_rsp_valid); end
        total++; if (a_ready !== 4'b0000) begin bad++; $display("FAIL mrst_ready: got %b want 0000", a_ready); end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        total++; if (a_rsp_valid !== 4'b0000) begin bad++; $display("FAIL mrst_after: got %b want 0000", a_rsp_valid); end
        total++; if (a_ready !== 4'b0100) begin bad++; $display("FAIL mrst_ptr: got %b want 0100", a_ready); end
        @(posedge clk); #1;
        a_valid = '0;
        total++; if (a_rsp_valid !== 4'b0100 || a_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL mrst_resume: got %b/%h want 0100/deadbeef", a_rsp_valid, a_rdata); end
    endtask

    task automatic test_back_to_back();
        drive_a(2, 1'b1, 9'd9, 32'hCAFEF00D, 4'hF);
        @(posedge clk); #1;
        total++; if (a_rsp_valid !== 4'b0100) begin bad++; $display("FAIL b2b_wr_rsp: got %b want 0100", a_rsp_valid); end
        drive_a(0, 1'b0, 9'd9, 32'h0, 4'h0);
        total++; if (a_ready !== 4'b0001) begin bad++; $display("FAIL b2b_rd_ready: got %b want 0001", a_ready); end
        step();
        total++; if (a_rsp_valid !== 4'b0001 || a_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL b2b_rd: got %b/%h want 0001/cafef00d", a_rsp_valid, a_rdata); end
    endtask

    task automatic test_fixed();
        @(negedge clk);
        b_valid = 4'b1111;
        b_write = 4'b0000;
        b_addr  = '0;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (b_ready !== 4'b0001) begin bad++; $display("FAIL fix_grant[%0d]: got %b want 0001", k, b_ready); end
            @(posedge clk); #1;
            total++; if (b_rsp_valid !== 4'b0001) begin bad++; $display("FAIL fix_rsp[%0d]: got %b want 0001", k, b_rsp_valid); end
            @(negedge clk);
        end
        b_valid = 4'b1100;
        #1;
        total++; if (b_ready !== 4'b0100) begin bad++; $display("FAIL fix_low: got %b want 0100", b_ready); end
        step();
        total++; if (b_rsp_valid !== 4'b0100) begin bad++; $display("FAIL fix_low_rsp: got %b want 0100", b_rsp_valid); end
    endtask

    task automatic test_range();
        drive_b(0, 1'b1, 9'd0, 32'h01010101, 4'hF);
        step();
        drive_b(1, 1'b1, 9'd499, 32'h49949949, 4'hF);
        step();
        total++; if (b_err !== 1'b0) begin bad++; $display("FAIL rng_499_err: got %b want 0", b_err); end
        drive_b(1, 1'b0, 9'd499, 32'h0, 4'h0);
        step();
        total++; if (b_rdata !== 32'h49949949 || b_err !== 1'b0) begin bad++; $display("FAIL rng_rd499: got %h/%b want 49949949/0", b_rdata, b_err); end
        drive_b(2, 1'b0, 9'd505, 32'h0, 4'h0);
        step();
        total++; if (b_rsp_valid !== 4'b0100 || b_rdata !== 32'h0 || b_err !== 1'b1) begin bad++; $display("FAIL rng_rd505: got %b/%h/%b want 0100/0/1", b_rsp_valid, b_rdata, b_err); end
        drive_b(3, 1'b1, 9'd510, 32'hFFFFFFFF, 4'hF);
        step();
        total++; if (b_rsp_valid !== 4'b1000 || b_rdata !== 32'h0 || b_err !== 1'b1) begin bad++; $display("FAIL rng_wr510: got %b/%h/%b want 1000/0/1", b_rsp_valid, b_rdata, b_err); end
        @(posedge clk); #1;
        total++; if (b_rsp_valid !== 4'b0000 || b_err !== 1'b1) begin bad++; $display("FAIL rng_err_hold: got %b/%b want 0000/1", b_rsp_valid, b_err); end
        drive_b(0, 1'b0, 9'd0, 32'h0, 4'h0);
        step();
        total++; if (b_rdata !== 32'h01010101 || b_err !== 1'b0) begin bad++; $display("FAIL rng_rd0: got %h/%b want 01010101/0", b_rdata, b_err); end
        drive_b(0, 1'b0, 9'd500, 32'h0, 4'h0);
        step();
        total++; if (b_rdata !== 32'h0 || b_err !== 1'b1) begin bad++; $display("FAIL rng_rd500: got %h/%b want 0/1", b_rdata, b_err); end
    endtask

    initial begin
        reset   = 1'b1;
        a_valid = '0; a_write = '0; a_addr = '0; a_wdata = '0; a_mask = '0;
        b_valid = '0; b_write = '0; b_addr = '0; b_wdata = '0; b_mask = '0;
        test_reset();
        test_write_read();
        test_masked();
        test_zero_mask();
        test_rr();
        test_rr_skip();
        test_mid_reset();
        test_back_to_back();
        test_fixed();
        test_range();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
